// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register indices,
// exception codes, SR/Cause field positions and the handler mode type.
package cp0_pkg;

   // CP0 register indices as seen by mfc0/mtc0
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   // Exception codes produced by the M-stage decoder (0 means none / interrupt)
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR field positions
   localparam int SR_IE_BIT  = 0;
   localparam int SR_EXL_BIT = 1;
   localparam int SR_IM_LO   = 10;
   localparam int SR_IM_HI   = 15;

   // Cause field positions
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD_BIT = 31;

   // Processor mode; the encoding doubles as SR.EXL
   typedef enum logic {
      MODE_NORMAL  = 1'b0,
      MODE_HANDLER = 1'b1
   } cp0_mode_e;

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational exception/interrupt request generation for CP0.
// An enabled, unmasked interrupt outranks a synchronous exception; both
// are suppressed while the handler is active (EXL set).
module cp0_req_gen
   import cp0_pkg::*;
(
   input  logic [5:0] hwint,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic [4:0] exc_code_in,
   output logic       req,
   output logic [4:0] exc_code
);

   logic int_req;
   logic exc_req;

   // Request terms and the ExcCode to record, with interrupt priority
   always_comb begin
      int_req  = (|(hwint & im)) & ie & ~exl;
      exc_req  = (exc_code_in != EXC_INT) & ~exl;
      req      = int_req | exc_req;
      exc_code = int_req ? EXC_INT : exc_code_in;
   end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers, exception/interrupt
// arbitration and the one-cycle flush/redirect request.
// Optional feature macro: CP0_BADVADDR_EN adds BadAddrIn and register 8
// (BadVAddr); without it register 8 reads 0.
//
// Req is a single-cycle strobe with no back-pressure: when Req is high the
// pipeline must flush and redirect in that same cycle; CP0 commits the
// exception state (EXL, BD, ExcCode, EPC) at the closing clock edge.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h2021_0007,
   parameter logic [5:0]  IM_RESET   = 6'h00
)(
   input  logic        clk,
   input  logic        reset,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] BadAddrIn,
`endif
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic        EXLClr,
   input  logic [5:0]  HWInt,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] DOut
);

   // SR state; EXL is carried by the mode register
   logic [5:0]  sr_im;
   logic        sr_ie;
   cp0_mode_e   mode;

   // Cause state
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;

   logic [31:0] epc;
   logic [4:0]  sel_exc_code;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   cp0_req_gen u_req_gen (
      .hwint       (HWInt),
      .im          (sr_im),
      .ie          (sr_ie),
      .exl         (mode == MODE_HANDLER),
      .exc_code_in (ExcCodeIn),
      .req         (Req),
      .exc_code    (sel_exc_code)
   );

   // Mode, SR, Cause and EPC update; an exception takes precedence over mtc0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_im     <= IM_RESET;
         sr_ie     <= 1'b0;
         mode      <= MODE_NORMAL;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'h00;
         cause_exc <= EXC_INT;
         epc       <= 32'h0;
      end else begin
         cause_ip <= HWInt;
         if (Req) begin
            mode      <= MODE_HANDLER;
            cause_bd  <= BDIn;
            cause_exc <= sel_exc_code;
            epc       <= BDIn ? (PC - 32'd4) : PC;
         end else begin
            if (EXLClr) begin
               mode <= MODE_NORMAL;
            end
            if (WE) begin
               case (A2)
                  REG_SR: begin
                     sr_im <= DIn[SR_IM_HI:SR_IM_LO];
                     sr_ie <= DIn[SR_IE_BIT];
                     mode  <= DIn[SR_EXL_BIT] ? MODE_HANDLER : MODE_NORMAL;
                  end
                  REG_EPC: epc <= DIn;
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr;

   // Capture the faulting address on address-error exceptions
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         badvaddr <= 32'h0;
      end else if (Req && (sel_exc_code == EXC_ADEL || sel_exc_code == EXC_ADES)) begin
         badvaddr <= ((PC[1:0] != 2'b00) && (sel_exc_code == EXC_ADEL)) ? PC : BadAddrIn;
      end
   end
`endif

   // Pack SR and Cause into their architectural 32-bit layouts
   always_comb begin
      sr_word                          = 32'h0;
      sr_word[SR_IM_HI:SR_IM_LO]       = sr_im;
      sr_word[SR_EXL_BIT]              = (mode == MODE_HANDLER);
      sr_word[SR_IE_BIT]               = sr_ie;
      cause_word                       = 32'h0;
      cause_word[CAUSE_BD_BIT]         = cause_bd;
      cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
      cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
   end

   // mfc0 read mux; reflects state before the edge (no write bypass)
   always_comb begin
      DOut = 32'h0;
      case (A1)
         REG_SR:       DOut = sr_word;
         REG_CAUSE:    DOut = cause_word;
         REG_EPC:      DOut = epc;
         REG_PRID:     DOut = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
         REG_BADVADDR: DOut = badvaddr;
`endif
         default:      DOut = 32'h0;
      endcase
   end

   assign EPCOut = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit (default build, CP0_BADVADDR_EN undefined).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic        EXLClr;
   logic [5:0]  HWInt;
   logic        Req;
   logic [31:0] EPCOut;
   logic [31:0] DOut;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   cp0_unit dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .DIn       (DIn),
      .WE        (WE),
      .PC        (PC),
      .BDIn      (BDIn),
      .ExcCodeIn (ExcCodeIn),
      .EXLClr    (EXLClr),
      .HWInt     (HWInt),
      .Req       (Req),
      .EPCOut    (EPCOut),
      .DOut      (DOut)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // compare one observed value against one expected value
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      WE = 1'b0; A2 = 5'd0; DIn = 32'h0; BDIn = 1'b0;
      ExcCodeIn = 5'd0; EXLClr = 1'b0;
   endtask

   // let one rising edge pass, return on the following falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
      WE = 1'b1; A2 = idx; DIn = data;
      step();
      WE = 1'b0;
   endtask

   task automatic eret();
      EXLClr = 1'b1;
      step();
      EXLClr = 1'b0;
   endtask

   // scoreboard: expectation queued as the read is driven, popped on sampling
   task automatic expect_read(input logic [4:0] idx, input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      A1 = idx;
      #1;
      check(tag_q.pop_front(), DOut, exp_q.pop_front());
   endtask

   task automatic expect_req(input logic exp, input string tag);
      exp_q.push_back({31'b0, exp});
      tag_q.push_back(tag);
      #1;
      check(tag_q.pop_front(), {31'b0, Req}, exp_q.pop_front());
   endtask

   task automatic expect_epcout(input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      #1;
      check(tag_q.pop_front(), EPCOut, exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] old_epc;
      logic [31:0] new_epc;

      reset = 1'b0; A1 = 5'd0; PC = 32'h0; HWInt = 6'h00;
      idle_inputs();
      repeat (2) @(negedge clk);

      // reset state
      expect_req(1'b0, "rst_req");
      expect_read(5'd12, 32'h0000_0000, "rst_sr");
      expect_read(5'd13, 32'h0000_0000, "rst_cause");
      expect_read(5'd14, 32'h0000_0000, "rst_epc");
      expect_epcout(32'h0, "rst_epcout");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // interrupt: IM=3F, IE=1, HWInt=04
      mtc0(5'd12, 32'h0000_FC01);
      expect_read(5'd12, 32'h0000_FC01, "sr_write");
      PC = 32'h0000_2000;
      HWInt = 6'h04;
      expect_req(1'b1, "int_req");
      step();
      expect_req(1'b0, "int_masked_by_exl");
      HWInt = 6'h00;
      expect_read(5'd13, 32'h0000_1000, "int_cause");
      expect_read(5'd12, 32'h0000_FC03, "int_sr_exl");
      expect_read(5'd14, 32'h0000_2000, "int_epc");
      eret();
      expect_read(5'd12, 32'h0000_FC01, "int_eret_sr");

      // overflow in a delay slot
      ExcCodeIn = 5'h0c; PC = 32'h0000_3010; BDIn = 1'b1;
      expect_req(1'b1, "ov_req");
      step();
      idle_inputs();
      expect_read(5'd14, 32'h0000_300C, "ov_epc");
      expect_read(5'd13, 32'h8000_0030, "ov_cause");
      expect_epcout(32'h0000_300C, "ov_epcout");

      // exception while EXL=1 is ignored, then taken after eret
      ExcCodeIn = 5'd4; PC = 32'h0000_4444;
      expect_req(1'b0, "adel_blocked_req");
      step();
      idle_inputs();
      expect_read(5'd14, 32'h0000_300C, "adel_blocked_epc");
      eret();
      expect_read(5'd12, 32'h0000_FC01, "adel_eret_sr");
      ExcCodeIn = 5'd4; PC = 32'h0000_5000;
      expect_req(1'b1, "adel_req");
      step();
      idle_inputs();
      expect_read(5'd14, 32'h0000_5000, "adel_epc");
      expect_read(5'd13, 32'h0000_0010, "adel_cause");
      eret();

      // mtc0 EPC in the exception cycle is dropped
      WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
      ExcCodeIn = 5'd10; PC = 32'h0000_3000;
      expect_req(1'b1, "ri_req");
      step();
      idle_inputs();
      expect_read(5'd14, 32'h0000_3000, "ri_epc_write_dropped");
      expect_read(5'd13, 32'h0000_0028, "ri_cause");
      eret();

      // interrupt beats a simultaneous exception
      mtc0(5'd12, 32'h0000_0401);
      expect_read(5'd12, 32'h0000_0401, "sr_im01");
      HWInt = 6'h01; ExcCodeIn = 5'd5; PC = 32'h0000_6004;
      expect_req(1'b1, "prio_req");
      step();
      idle_inputs();
      HWInt = 6'h00;
      expect_read(5'd13, 32'h0000_0400, "prio_cause");
      expect_read(5'd14, 32'h0000_6004, "prio_epc");
      eret();

      // delay-slot EPC wraps below zero
      ExcCodeIn = 5'd12; PC = 32'h0000_0002; BDIn = 1'b1;
      step();
      idle_inputs();
      expect_read(5'd14, 32'hFFFF_FFFE, "wrap_epc");
      expect_read(5'd13, 32'h8000_0030, "wrap_cause");
      eret();

      // random mtc0 EPC writes; the read in the write cycle shows the old value
      for (int i = 0; i < 4; i++) begin
         old_epc = EPCOut;
         new_epc = {$urandom_range(32'hFFFF, 0), $urandom_range(32'hFFFF, 0)} & 32'hFFFF_FFFC;
         WE = 1'b1; A2 = 5'd14; DIn = new_epc;
         A1 = 5'd14;
         exp_q.push_back(old_epc);
         tag_q.push_back("epc_no_bypass");
         #1;
         check(tag_q.pop_front(), DOut, exp_q.pop_front());
         step();
         WE = 1'b0;
         expect_read(5'd14, new_epc, "epc_rand_write");
      end

      // writes to read-only / unmapped indices are ignored
      mtc0(5'd13, 32'hFFFF_FFFF);
      expect_read(5'd13, 32'h8000_0030, "cause_readonly");
      mtc0(5'd7, 32'h1234_5678);
      expect_read(5'd7, 32'h0000_0000, "unmapped_7");
      expect_read(5'd8, 32'h0000_0000, "badvaddr_absent");
      mtc0(5'd15, 32'h1111_1111);
      expect_read(5'd15, 32'h2021_0007, "prid_readonly");

      // reset in the middle of a handler
      ExcCodeIn = 5'd12; PC = 32'h0000_7000;
      step();
      idle_inputs();
      expect_read(5'd12, 32'h0000_0403, "pre_reset_sr");
      reset = 1'b0;
      expect_read(5'd12, 32'h0000_0000, "midrst_sr");
      expect_read(5'd14, 32'h0000_0000, "midrst_epc");
      expect_read(5'd13, 32'h0000_0000, "midrst_cause");
      expect_req(1'b0, "midrst_req");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      expect_read(5'd15, 32'h2021_0007, "prid");
      expect_read(5'd7, 32'h0000_0000, "idx7");
      ExcCodeIn = 5'd10; PC = 32'h0000_8000;
      expect_req(1'b1, "post_reset_req");
      idle_inputs();

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
